// File: rtl/display_scheduler.sv
// Display scheduler: digit-scan cadence, page select (time/alarm/stopwatch),
// edit-digit blink and alarm-ring flash for the shared 4-digit 7-seg display.
// Ports: CP50 clock, CR sync active-high reset, KEY_NEXT page key,
//   ALARM_RING/EDIT_EN/EDIT_DIG display modifiers, TIME_HEX/ALARM_HEX/SW_HEX
//   page sources (digit n in [7n+6:7n]); Choose active-low digit enables,
//   HEX segment code (7F blank), PAGE current stored page.
module display_scheduler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        CP50,
  input  logic        CR,
  input  logic        KEY_NEXT,
  input  logic        ALARM_RING,
  input  logic        EDIT_EN,
  input  logic [1:0]  EDIT_DIG,
  input  logic [27:0] TIME_HEX,
  input  logic [27:0] ALARM_HEX,
  input  logic [27:0] SW_HEX,
  output logic [3:0]  Choose,
  output logic [6:0]  HEX,
  output logic [1:0]  PAGE
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    PG_TIME  = 2'b00,
    PG_ALARM = 2'b01,
    PG_SW    = 2'b10
  } page_t;

  page_t         page;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [1:0]    idx;
  logic          key_q;

  logic          slot_end;
  logic          blink_end;
  logic          key_rise;
  logic [1:0]    nxt;
  logic [27:0]   src;
  logic [6:0]    field;
  logic          dark;

  assign slot_end  = (scan_cnt == SCAN_LAST);
  assign blink_end = (blink_cnt == BLINK_LAST);
  // key_q resets high so a key held through reset is not an edge
  assign key_rise  = KEY_NEXT & ~key_q;
  assign nxt       = idx + 2'd1;
  assign PAGE      = page;

  // ringing alarm always shows the time, whatever page is stored
  always_comb begin
    src = TIME_HEX;
    if (!ALARM_RING) begin
      case (page)
        PG_ALARM: src = ALARM_HEX;
        PG_SW:    src = SW_HEX;
        default:  src = TIME_HEX;
      endcase
    end
  end

  always_comb begin
    field = src[6:0];
    case (nxt)
      2'd0: field = src[6:0];
      2'd1: field = src[13:7];
      2'd2: field = src[20:14];
      2'd3: field = src[27:21];
      default: field = src[6:0];
    endcase
  end

  assign dark = phase & (ALARM_RING | (EDIT_EN & (EDIT_DIG == nxt)));

  // page FSM; edges seen while ringing are dropped, not deferred
  always_ff @(posedge CP50) begin
    if (CR) begin
      page  <= PG_TIME;
      key_q <= 1'b1;
    end else begin
      key_q <= KEY_NEXT;
      case (page)
        PG_TIME:  if (key_rise && !ALARM_RING) page <= PG_ALARM;
        PG_ALARM: if (key_rise && !ALARM_RING) page <= PG_SW;
        PG_SW:    if (key_rise && !ALARM_RING) page <= PG_TIME;
        default:  page <= PG_TIME;
      endcase
    end
  end

  always_ff @(posedge CP50) begin
    if (CR) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_end) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // outputs load the upcoming digit on the edge closing a slot
  always_ff @(posedge CP50) begin
    if (CR) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      Choose   <= 4'b1110;
      HEX      <= 7'h7F;
    end else if (slot_end) begin
      scan_cnt <= '0;
      idx      <= nxt;
      Choose   <= ~(4'b0001 << nxt);
      HEX      <= dark ? 7'h7F : field;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler (SCAN_DIV=4, BLINK_DIV=16): scoreboard of
// per-cycle expected outputs plus directed scan/page/blink/ring/reset checks.
module tb_display_scheduler;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;

  logic        clk;
  logic        CR;
  logic        KEY_NEXT;
  logic        ALARM_RING;
  logic        EDIT_EN;
  logic [1:0]  EDIT_DIG;
  logic [27:0] TIME_HEX;
  logic [27:0] ALARM_HEX;
  logic [27:0] SW_HEX;
  logic [3:0]  Choose;
  logic [6:0]  HEX;
  logic [1:0]  PAGE;

  int n_chk  = 0;
  int n_fail = 0;

  display_scheduler #(
    .SCAN_DIV (SCAN),
    .BLINK_DIV(BLINK)
  ) dut (
    .CP50      (clk),
    .CR        (CR),
    .KEY_NEXT  (KEY_NEXT),
    .ALARM_RING(ALARM_RING),
    .EDIT_EN   (EDIT_EN),
    .EDIT_DIG  (EDIT_DIG),
    .TIME_HEX  (TIME_HEX),
    .ALARM_HEX (ALARM_HEX),
    .SW_HEX    (SW_HEX),
    .Choose    (Choose),
    .HEX       (HEX),
    .PAGE      (PAGE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] fld(input logic [27:0] v, input int i);
    return v[i*7 +: 7];
  endfunction

  function automatic int idx_of(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 0;
    endcase
  endfunction

  // reference model: runs on each rising edge, pushes expected outputs
  bit          m_valid = 0;
  int          m_scan, m_blink, m_idx, m_page;
  bit          m_phase, m_key;
  logic [3:0]  m_choose;
  logic [6:0]  m_hex;
  logic [12:0] sb[$];

  always @(posedge clk) begin
    bit          bnd, bw, dark;
    logic [27:0] s;
    if (CR) begin
      m_valid  = 1;
      m_scan   = 0;
      m_blink  = 0;
      m_phase  = 0;
      m_idx    = 0;
      m_page   = 0;
      m_key    = 1;
      m_choose = 4'b1110;
      m_hex    = 7'h7F;
    end else if (m_valid) begin
      bnd = (m_scan == SCAN - 1);
      bw  = (m_blink == BLINK - 1);
      if (bnd) begin
        m_idx    = (m_idx + 1) % 4;
        m_choose = 4'hF ^ (4'h1 << m_idx);
        if (ALARM_RING)       s = TIME_HEX;
        else if (m_page == 1) s = ALARM_HEX;
        else if (m_page == 2) s = SW_HEX;
        else                  s = TIME_HEX;
        dark  = m_phase && (ALARM_RING || (EDIT_EN && EDIT_DIG == m_idx));
        m_hex = dark ? 7'h7F : fld(s, m_idx);
      end
      if (KEY_NEXT && !m_key && !ALARM_RING) m_page = (m_page + 1) % 3;
      m_key  = KEY_NEXT;
      if (bw) m_phase = !m_phase;
      m_scan  = bnd ? 0 : m_scan + 1;
      m_blink = bw ? 0 : m_blink + 1;
    end
    if (m_valid) sb.push_back({m_choose, m_hex, 2'(m_page)});
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        check("sb_choose", Choose, e[12:9]);
        check("sb_hex", HEX, e[8:2]);
        check("sb_page", PAGE, e[1:0]);
      end
    end
  end

  task automatic wait_slot();
    logic [3:0] prev;
    bit hit;
    prev = Choose;
    hit  = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      @(negedge clk);
      if (Choose !== prev) hit = 1;
    end
    check("slot_timeout", hit, 1);
  endtask

  task automatic wait_scan(input int v);
    for (int i = 0; i < 8 && m_scan != v; i++) @(negedge clk);
  endtask

  logic [3:0] ch_tab[5];
  logic [6:0] hx_tab[5];

  initial begin
    bit         seen_dark, seen_lit, found;
    logic [3:0] mask;
    int         ix;

    ch_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    hx_tab = '{7'h7F, 7'h01, 7'h02, 7'h03, 7'h00};

    CR         = 1'b1;
    KEY_NEXT   = 1'b0;
    ALARM_RING = 1'b0;
    EDIT_EN    = 1'b0;
    EDIT_DIG   = 2'd0;
    TIME_HEX   = {7'h03, 7'h02, 7'h01, 7'h00};
    ALARM_HEX  = {7'h13, 7'h12, 7'h11, 7'h10};
    SW_HEX     = {7'h23, 7'h22, 7'h21, 7'h20};

    // reset then scan: each value held 4 cycles
    @(negedge clk);
    check("rst_choose", Choose, 4'b1110);
    check("rst_hex", HEX, 7'h7F);
    check("rst_page", PAGE, 2'b00);
    CR = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      check("scan_choose", Choose, ch_tab[k/4]);
      check("scan_hex", HEX, hx_tab[k/4]);
    end

    // page cycling
    wait_scan(0);
    KEY_NEXT = 1'b1;
    @(negedge clk);
    check("page_alarm", PAGE, 2'b01);
    KEY_NEXT = 1'b0;
    wait_slot();
    check("hex_alarm", HEX, fld(ALARM_HEX, idx_of(Choose)));
    wait_scan(0);
    KEY_NEXT = 1'b1;
    @(negedge clk);
    check("page_sw", PAGE, 2'b10);
    KEY_NEXT = 1'b0;
    wait_slot();
    check("hex_sw", HEX, fld(SW_HEX, idx_of(Choose)));
    // edge coincident with slot boundary: load uses old page
    wait_scan(3);
    KEY_NEXT = 1'b1;
    @(negedge clk);
    check("page_time", PAGE, 2'b00);
    check("hex_oldpage", HEX, fld(SW_HEX, idx_of(Choose)));
    KEY_NEXT = 1'b0;
    wait_slot();
    check("hex_time", HEX, fld(TIME_HEX, idx_of(Choose)));

    // edit blink on digit 2
    EDIT_EN   = 1'b1;
    EDIT_DIG  = 2'd2;
    seen_dark = 0;
    seen_lit  = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      ix = idx_of(Choose);
      if (ix == 2) begin
        check("edit_dig", (HEX == 7'h7F) || (HEX == fld(TIME_HEX, 2)), 1);
        if (HEX == 7'h7F) seen_dark = 1;
        else seen_lit = 1;
      end else begin
        check("edit_other", HEX != 7'h7F, 1);
      end
    end
    check("edit_dark_seen", seen_dark, 1);
    check("edit_lit_seen", seen_lit, 1);
    EDIT_EN = 1'b0;

    // alarm override on stopwatch page
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      KEY_NEXT = 1'b1;
      @(negedge clk);
      KEY_NEXT = 1'b0;
    end
    check("ring_pre_page", PAGE, 2'b10);
    ALARM_RING = 1'b1;
    wait_slot();
    mask = 4'h0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 10) KEY_NEXT = 1'b1;
      if (k == 12) KEY_NEXT = 1'b0;
      ix = idx_of(Choose);
      check("ring_page", PAGE, 2'b10);
      check("ring_src", (HEX == 7'h7F) || (HEX == fld(TIME_HEX, ix)), 1);
      if (HEX == 7'h7F) mask[ix] = 1'b1;
    end
    check("ring_all_blank", mask, 4'hF);
    ALARM_RING = 1'b0;
    wait_slot();
    wait_slot();
    check("ring_after_page", PAGE, 2'b10);
    check("ring_after_hex", HEX, fld(SW_HEX, idx_of(Choose)));

    // reset mid-operation on alarm page, index 3, prescaler 2
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      KEY_NEXT = 1'b1;
      @(negedge clk);
      KEY_NEXT = 1'b0;
    end
    check("mid_pre_page", PAGE, 2'b01);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (m_idx == 3 && m_scan == 2) found = 1;
    end
    check("mid_align", found, 1);
    CR = 1'b1;
    @(negedge clk);
    CR = 1'b0;
    check("mid_choose", Choose, 4'b1110);
    check("mid_hex", HEX, 7'h7F);
    check("mid_page", PAGE, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("mid_bnd", Choose, (k < 4) ? 4'b1110 : 4'b1101);
    end

    // key held through reset
    KEY_NEXT = 1'b1;
    CR = 1'b1;
    @(negedge clk);
    CR = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("held_page", PAGE, 2'b00);
    end
    KEY_NEXT = 1'b0;
    @(negedge clk);
    KEY_NEXT = 1'b1;
    @(negedge clk);
    check("held_release", PAGE, 2'b01);
    KEY_NEXT = 1'b0;

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) KEY_NEXT = ~KEY_NEXT;
      if ($urandom_range(0, 40) == 0) ALARM_RING = ~ALARM_RING;
      if ($urandom_range(0, 20) == 0) EDIT_EN = ~EDIT_EN;
      if ($urandom_range(0, 10) == 0) EDIT_DIG = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) TIME_HEX = 28'($urandom);
      if ($urandom_range(0, 15) == 0) SW_HEX = 28'($urandom);
      CR = ($urandom_range(0, 99) == 0);
    end
    CR = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
